// File: rtl/pseudo_linear_train_ctrl_if.sv
// Bundle between the training sequencer and its driver: run control, LFSR/RAM addressing, datapath strobes, status.
// master drives run control and datapath feedback; slave is the sequencer.
interface pseudo_linear_train_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_samples;
  logic [ADDR_W-1:0] lfsr_addr;
  logic              dp_error;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              img_valid;
  logic              upd_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sample_count;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output start, abort, num_samples, lfsr_addr, dp_error,
    input  ram_en, ram_addr, img_valid, upd_en, busy, done, sample_count, err_count
  );

  modport slave (
    input  start, abort, num_samples, lfsr_addr, dp_error,
    output ram_en, ram_addr, img_valid, upd_en, busy, done, sample_count, err_count
  );
endinterface

// File: rtl/pseudo_linear_train_ctrl.sv
// Training-run sequencer: per sample READ -> EVAL (-> UPDATE on error); 2 cycles/sample, 3 with an update.
// No backpressure: runs back-to-back until the target count; start is ignored while busy, abort drops to IDLE.
module pseudo_linear_train_ctrl #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  pseudo_linear_train_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EVAL   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  sample_count_q, sample_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]  sample_inc;
  logic              last_sample;
  logic              ram_en, img_valid, upd_en, busy, done;

  assign sample_inc  = sample_count_q + CNT_W'(1);
  assign last_sample = (sample_inc == target_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      target_q       <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      ram_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      ram_addr_q     <= ram_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    ram_addr_d     = ram_addr_q;
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // abort alongside start suppresses the start entirely
          if (bus.start && !bus.abort) begin
            target_d       = bus.num_samples;
            sample_count_d = '0;
            err_count_d    = '0;
            if (bus.num_samples != '0) begin
              state_d    = S_READ;
              ram_addr_d = bus.lfsr_addr;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_READ: state_d = S_EVAL;
        S_EVAL: begin
          if (bus.dp_error) begin
            state_d = S_UPDATE;
          end else begin
            sample_count_d = sample_inc;
            if (last_sample) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_READ;
              ram_addr_d = bus.lfsr_addr;
            end
          end
        end
        S_UPDATE: begin
          sample_count_d = sample_inc;
          if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          if (last_sample) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_READ;
            ram_addr_d = bus.lfsr_addr;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    img_valid = 1'b0;
    upd_en    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_READ:   ram_en    = 1'b1;
      S_EVAL:   img_valid = 1'b1;
      S_UPDATE: upd_en    = !bus.abort;
      S_DONE:   done      = !bus.abort;
      default:  ;
    endcase
  end

  assign bus.ram_en       = ram_en;
  assign bus.img_valid    = img_valid;
  assign bus.upd_en       = upd_en;
  assign bus.done         = done;
  assign bus.busy         = busy;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.sample_count = sample_count_q;
  assign bus.err_count    = err_count_q;

endmodule

// File: tb/tb_pseudo_linear_train_ctrl.sv
// Directed bench for the training sequencer: strobe patterns per cycle, counts, abort, reset and a 4-bit counter run.
module tb_pseudo_linear_train_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pseudo_linear_train_ctrl_if #(.ADDR_W(14), .CNT_W(16)) bus ();
  pseudo_linear_train_ctrl #(.ADDR_W(14), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  pseudo_linear_train_ctrl_if #(.ADDR_W(14), .CNT_W(4)) bus4 ();
  pseudo_linear_train_ctrl #(.ADDR_W(14), .CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  function automatic logic [3:0] outs0();
    return {bus.ram_en, bus.img_valid, bus.upd_en, bus.done};
  endfunction

  function automatic logic [3:0] outs4();
    return {bus4.ram_en, bus4.img_valid, bus4.upd_en, bus4.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    checks++; if (outs0() !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", outs0()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.ram_addr !== 14'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d expected 0", bus.ram_addr); end
    checks++; if (bus.sample_count !== 16'd0 || bus.err_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus.sample_count, bus.err_count); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_no_error();
    logic [3:0] exp;
    bus.num_samples = 16'd3; bus.dp_error = 1'b0; bus.lfsr_addr = 14'd100; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp = (c == 7) ? 4'b0001 : ((c % 2) == 1) ? 4'b1000 : 4'b0100;
      checks++; if (outs0() !== exp) begin errors++; $display("FAIL no_err_strobes c%0d: got %b expected %b", c, outs0(), exp); end
      if (exp[3]) begin
        checks++; if (bus.ram_addr !== 14'(100 + c - 1)) begin
          errors++; $display("FAIL no_err_ram_addr c%0d: got %0d expected %0d", c, bus.ram_addr, 100 + c - 1); end
      end
      bus.lfsr_addr = 14'(100 + c);
      if (c < 7) step();
    end
    checks++; if (bus.sample_count !== 16'd3 || bus.err_count !== 16'd0) begin
      errors++; $display("FAIL no_err_counts: got %0d/%0d expected 3/0", bus.sample_count, bus.err_count); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.sample_count !== 16'd3) begin
      errors++; $display("FAIL no_err_hold: got busy=%b cnt=%0d expected busy=0 cnt=3", bus.busy, bus.sample_count); end
  endtask

  task automatic test_all_errors();
    logic [3:0] exp;
    bus.num_samples = 16'd2; bus.dp_error = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp = (c == 7) ? 4'b0001 : ((c % 3) == 1) ? 4'b1000 : ((c % 3) == 2) ? 4'b0100 : 4'b0010;
      checks++; if (outs0() !== exp) begin errors++; $display("FAIL all_err_strobes c%0d: got %b expected %b", c, outs0(), exp); end
      if (c == 4) begin
        checks++; if (bus.sample_count !== 16'd1 || bus.err_count !== 16'd1) begin
          errors++; $display("FAIL all_err_mid_counts: got %0d/%0d expected 1/1", bus.sample_count, bus.err_count); end
      end
      if (c < 7) step();
    end
    checks++; if (bus.sample_count !== 16'd2 || bus.err_count !== 16'd2) begin
      errors++; $display("FAIL all_err_counts: got %0d/%0d expected 2/2", bus.sample_count, bus.err_count); end
    bus.dp_error = 1'b0;
    step();
  endtask

  task automatic test_zero_samples();
    bus.num_samples = 16'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (outs0() !== 4'b0001 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL zero_done: got strobes=%b busy=%b expected 0001/1", outs0(), bus.busy); end
    step();
    checks++; if (outs0() !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle: got strobes=%b busy=%b expected 0000/0", outs0(), bus.busy); end
    checks++; if (bus.sample_count !== 16'd0 || bus.err_count !== 16'd0) begin
      errors++; $display("FAIL zero_counts: got %0d/%0d expected 0/0", bus.sample_count, bus.err_count); end
  endtask

  task automatic test_start_while_busy();
    bus.num_samples = 16'd3; bus.dp_error = 1'b0; bus.start = 1'b1;
    step();
    bus.num_samples = 16'd1;
    for (int c = 1; c <= 7; c++) begin
      if (c == 6) bus.start = 1'b0;
      checks++; if (bus.done !== (c == 7)) begin
        errors++; $display("FAIL busy_start_done c%0d: got %b expected %b", c, bus.done, (c == 7)); end
      if (c < 7) step();
    end
    checks++; if (bus.sample_count !== 16'd3) begin
      errors++; $display("FAIL busy_start_count: got %0d expected 3", bus.sample_count); end
    step();
  endtask

  task automatic test_start_abort_idle();
    bus.num_samples = 16'd2; bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.sample_count !== 16'd3) begin
      errors++; $display("FAIL start_abort_idle: got busy=%b cnt=%0d expected busy=0 cnt=3", bus.busy, bus.sample_count); end
  endtask

  task automatic test_abort_update();
    bus.num_samples = 16'd4; bus.dp_error = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++; if (outs0() !== 4'b0010) begin errors++; $display("FAIL abort_pre: got %b expected 0010", outs0()); end
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.upd_en !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_upd_gate: got upd=%b busy=%b expected 0/1", bus.upd_en, bus.busy); end
    step();
    bus.abort = 1'b0; bus.dp_error = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.sample_count !== 16'd0 || bus.err_count !== 16'd0) begin
      errors++; $display("FAIL abort_idle: got busy=%b cnt=%0d/%0d expected 0 0/0", bus.busy, bus.sample_count, bus.err_count); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (outs0() !== 4'b0000) begin errors++; $display("FAIL abort_quiet c%0d: got %b expected 0000", c, outs0()); end
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    bus.num_samples = 16'd1; bus.dp_error = 1'b0; bus.lfsr_addr = 14'd33; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    checks++; if (outs0() !== 4'b0100) begin errors++; $display("FAIL rst_mid_eval: got %b expected 0100", outs0()); end
    rst_n = 1'b0;
    #1;
    checks++; if (outs0() !== 4'b0000 || bus.busy !== 1'b0 || bus.ram_addr !== 14'd0) begin
      errors++; $display("FAIL rst_mid_async: got strobes=%b busy=%b addr=%0d expected 0000/0/0", outs0(), bus.busy, bus.ram_addr); end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (outs0() !== 4'b0000) begin errors++; $display("FAIL rst_mid_no_done c%0d: got %b expected 0000", c, outs0()); end
    end
    bus.lfsr_addr = 14'd77; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (outs0() !== 4'b1000 || bus.ram_addr !== 14'd77) begin
      errors++; $display("FAIL rst_mid_read: got %b addr=%0d expected 1000 addr=77", outs0(), bus.ram_addr); end
    step();
    step();
    checks++; if (outs0() !== 4'b0001 || bus.sample_count !== 16'd1) begin
      errors++; $display("FAIL rst_mid_done: got %b cnt=%0d expected 0001 cnt=1", outs0(), bus.sample_count); end
    step();
  endtask

  task automatic test_saturate_cnt4();
    int k = 0;
    int done_cycle = -1;
    bus4.num_samples = 4'd15; bus4.dp_error = 1'b1; bus4.lfsr_addr = 14'd5; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int c = 1; c <= 60 && done_cycle < 0; c++) begin
      checks++; if ($countones(outs4()) > 1) begin errors++; $display("FAIL sat_exclusive c%0d: got %b expected one-hot or zero", c, outs4()); end
      if (bus4.ram_en) begin
        checks++; if (bus4.ram_addr !== 14'(5 + 4 * k)) begin
          errors++; $display("FAIL sat_addr_seq k%0d: got %0d expected %0d", k, bus4.ram_addr, 5 + 4 * k); end
        k++;
        bus4.lfsr_addr = 14'(5 + 4 * k);
      end
      if (bus4.done) done_cycle = c;
      else step();
    end
    checks++; if (done_cycle != 46) begin errors++; $display("FAIL sat_done_cycle: got %0d expected 46", done_cycle); end
    checks++; if (k != 15) begin errors++; $display("FAIL sat_reads: got %0d expected 15", k); end
    checks++; if (bus4.err_count !== 4'd15 || bus4.sample_count !== 4'd15) begin
      errors++; $display("FAIL sat_counts: got %0d/%0d expected 15/15", bus4.sample_count, bus4.err_count); end
    bus4.dp_error = 1'b0;
    step(); step(); step();
    checks++; if (bus4.err_count !== 4'd15 || bus4.busy !== 1'b0) begin
      errors++; $display("FAIL sat_hold: got err=%0d busy=%b expected 15/0", bus4.err_count, bus4.busy); end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_samples = '0; bus.lfsr_addr = '0; bus.dp_error = 1'b0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.num_samples = '0; bus4.lfsr_addr = '0; bus4.dp_error = 1'b0;
    test_reset();
    test_no_error();
    test_all_errors();
    test_zero_samples();
    test_start_while_busy();
    test_start_abort_idle();
    test_abort_update();
    test_reset_mid_run();
    test_saturate_cnt4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pseudo_linear_train_ctrl.md
PSEUDO_LINEAR_TRAIN_CTRL -- requirements
Module: pseudo_linear_train_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning image RAM address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning sample/error counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a training run; honored only in IDLE.
REQ-006 SHALL have port abort, input, 1, synchronous run cancel.
REQ-007 SHALL have port num_samples, input, CNT_W, samples per run; captured when start is accepted.
REQ-008 SHALL have port lfsr_addr, input, ADDR_W, random sample address from the LFSR.
REQ-009 SHALL have port dp_error, input, 1, datapath prediction-vs-label error; meaningful only while img_valid=1.
REQ-010 SHALL have port ram_en, output, 1, image RAM read enable.
REQ-011 SHALL have port ram_addr, output, ADDR_W, registered image RAM address.
REQ-012 SHALL have port img_valid, output, 1, image word valid at datapath this cycle.
REQ-013 SHALL have port upd_en, output, 1, one-cycle enable for the parameter update (p <= p ^ re_d).
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle run-complete pulse.
REQ-016 SHALL have port sample_count, output, CNT_W, samples completed in the current/last run.
REQ-017 SHALL have port err_count, output, CNT_W, samples with dp_error=1 in the current/last run.

Function
REQ-018 SHALL implement FSM states IDLE, READ, EVAL, UPDATE, DONE.
REQ-019 IDLE: start=1 and num_samples!=0 SHALL latch num_samples, clear sample_count and err_count, capture ram_addr<=lfsr_addr, go to READ.
REQ-020 IDLE: start=1 and num_samples==0 SHALL clear both counts and go directly to DONE.
REQ-021 READ: ram_en=1 for exactly one cycle; next state EVAL (1-cycle RAM read latency).
REQ-022 EVAL: img_valid=1 for exactly one cycle; dp_error=1 -> UPDATE; dp_error=0 -> increment sample_count, then DONE if new count equals latched target, else READ.
REQ-023 UPDATE: upd_en=1 for exactly one cycle; increment sample_count and err_count; then DONE if new sample_count equals target, else READ.
REQ-024 Every transition into READ SHALL capture ram_addr<=lfsr_addr in that same clock edge.
REQ-025 DONE: done=1 for one cycle; next state IDLE; counts hold until next accepted start.
REQ-026 Per-sample latency SHALL be 2 cycles without error, 3 cycles with error; no idle cycles between samples.
REQ-027 err_count SHALL saturate at all-ones; sample_count cannot exceed target, no wrap.
REQ-028 start while busy=1 SHALL be ignored with no side effect.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, force upd_en=0 and done=0 in that cycle, and hold counts; abort in IDLE ignored.
REQ-030 abort and start together in IDLE SHALL leave FSM in IDLE.
REQ-031 ram_en, img_valid, upd_en, done SHALL be mutually exclusive in any cycle.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, all outputs 0, counts 0, ram_addr 0, latched target 0.
REQ-033 Reset mid-run SHALL discard the run; no done pulse follows reset release.
REQ-034 First start is accepted no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-035 num_samples=3, dp_error=0 always -> pattern READ/EVAL x3, done at cycle 7 after start, sample_count=3, err_count=0, upd_en never high.
REQ-036 num_samples=2, dp_error=1 always -> upd_en pulses twice, each one cycle after img_valid; done at cycle 7; err_count=2.
REQ-037 num_samples=0 -> done one cycle after start, busy high one cycle, counts 0, ram_en never high.
REQ-038 abort during UPDATE of sample 1 of 4 -> upd_en low that cycle, IDLE next, no done, sample_count=0.
REQ-039 rst_n pulse low during EVAL -> all outputs 0 immediately; later start with num_samples=1 completes normally.
REQ-040 CNT_W=4, num_samples=15, dp_error=1 -> err_count=15 and holds; lfsr_addr sequence 5,9,.. appears on ram_addr in order during each ram_en.
